// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants, scan FSM encoding and width helpers
// for the seven-segment scan controller.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    typedef enum logic {
        DISP = 1'b0,
        DEAD = 1'b1
    } scan_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Publisher-side inputs and display pins of the
// seven-segment scan controller.
interface seven_seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank;
    logic                  lz_en;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_tick;

    modport master (
        output load, value, dp_in, blank, lz_en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  load, value, dp_in, blank, lz_en,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_hex2seven_seg.sv
// Hex to active-low seven-segment decoder {g,f,e,d,c,b,a}.
// Code F decodes to all segments on.
module hex2seven_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        unique case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode display
// with dead time and a tear-free double-buffered value.
module seven_seg_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 500
) (
    input logic            clk,
    input logic            rst,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int IW = width_of(DIGITS);
    localparam int CW = width_of(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);
    localparam logic [CW-1:0] CNT_DISP = CW'(CLK_DIV - DEAD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    scan_state_t         state_q, state_d;
    logic [4*DIGITS-1:0] sh_val, act_val;
    logic [DIGITS-1:0]   sh_dp, act_dp;
    logic [DIGITS-1:0]   sh_blank, act_blank;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nib;
    logic [6:0]          dec_seg, seg_d;
    logic                dp_d, dark;
    logic                slot_end, frame_end;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                dp_q, tick_q;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= DISP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (slot_end)
            state_d = DISP;
        else if (DEAD_CYC > 0 && cnt == CNT_DISP)
            state_d = DEAD;
    end

    // A load on the frame boundary bypasses the shadow stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
        end else begin
            if (bus.load) begin
                sh_val   <= bus.value;
                sh_dp    <= bus.dp_in;
                sh_blank <= bus.blank;
            end
            if (frame_end) begin
                act_val   <= bus.load ? bus.value : sh_val;
                act_dp    <= bus.load ? bus.dp_in : sh_dp;
                act_blank <= bus.load ? bus.blank : sh_blank;
            end
        end
    end

    // lz_mask[i]: nibbles i..DIGITS-1 are all zero
    always_comb begin
        lz_mask = '0;
        for (int i = 0; i < DIGITS; i++)
            lz_mask[i] = ((act_val >> (4 * i)) == '0);
    end

    assign nib = act_val[{idx, 2'b00} +: 4];

    hex2seven_seg u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        dark  = act_blank[idx]
              | (bus.lz_en & (idx != '0) & lz_mask[idx]);
        seg_d = (nib == 4'hF) ? SEG_HEX_F : dec_seg;
        dp_d  = ~act_dp[idx];
        if (dark) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt == CNT_PRE) && (idx == IDX_LAST);
            if (state_q == DISP) begin
                an_q  <= ~(DIGITS'(1) << idx);
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end else begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with
// DIGITS=4, CLK_DIV=8, DEAD_CYC=2.
module tb_seven_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] an_s  [32];
    logic [6:0] seg_s [32];
    logic       dp_s  [32];
    logic       ft_s  [32];

    seven_seg_scan_ctrl_if #(.DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(
        .DIGITS   (4),
        .CLK_DIV  (8),
        .DEAD_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_now();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 100);
        vectors++;
        if (bus.frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL %s frame_tick wait: got %b want 1",
                     name, bus.frame_tick);
        end
    endtask

    // Start on a frame_tick sample; record the next 32 cycles.
    task automatic capture_frame(input int load_k);
        for (int k = 0; k < 32; k++) begin
            bus.load = (k == load_k);
            tick();
            an_s[k]  = bus.an;
            seg_s[k] = bus.seg;
            dp_s[k]  = bus.dp;
            ft_s[k]  = bus.frame_tick;
        end
        bus.load = 1'b0;
    endtask

    // Expected {an,seg,dp,frame_tick}: lit for slot cycles 1..6.
    function automatic logic [12:0] slot_word(
        input int k, input logic [27:0] segs, input logic [3:0] dps);
        int s, c;
        logic [3:0] a;
        logic [6:0] sg;
        logic d;
        s = k / 8;
        c = k % 8;
        a = 4'hF;
        sg = 7'h7F;
        d = 1'b1;
        if (c >= 1 && c <= 6) begin
            a[s] = 1'b0;
            sg = segs[7*s +: 7];
            d = dps[s];
        end
        return {a, sg, d, (k == 31)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_vals: got an=%b seg=%h dp=%b ft=%b want 1111/7f/1/0",
                     bus.an, bus.seg, bus.dp, bus.frame_tick);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1110, 7'h40, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_first_disp: got an=%b seg=%h dp=%b want 1110/40/1",
                     bus.an, bus.seg, bus.dp);
        end
    endtask

    task automatic test_frame(input string name, input int load_k,
                              input logic [27:0] segs, input logic [3:0] dps);
        logic [12:0] got, exp;
        capture_frame(load_k);
        for (int k = 0; k < 32; k++) begin
            got = {an_s[k], seg_s[k], dp_s[k], ft_s[k]};
            exp = slot_word(k, segs, dps);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                         name, k, got[12:9], got[8:2], got[1], got[0],
                         exp[12:9], exp[8:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_full_frame();
        bus.value = 16'h12AF;
        bus.dp_in = 4'b0100;
        load_now();
        wait_frame("full_frame");
        test_frame("full_frame", -1,
                   {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011);
    endtask

    task automatic test_leading_zeros();
        bus.lz_en = 1'b1;
        bus.dp_in = 4'b0000;
        bus.value = 16'h0050;
        load_now();
        wait_frame("lz_0050");
        test_frame("lz_0050", -1,
                   {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b1111);
        bus.value = 16'h0000;
        load_now();
        wait_frame("lz_0000");
        test_frame("lz_0000", -1,
                   {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
    endtask

    task automatic test_tear_free();
        bus.lz_en = 1'b0;
        bus.value = 16'h2222;
        load_now();
        wait_frame("tear_setup");
        bus.value = 16'h1111;
        test_frame("tear_old", 11, {4{7'b0100100}}, 4'b1111);
        test_frame("tear_new", -1, {4{7'b1111001}}, 4'b1111);
    endtask

    task automatic test_coincident();
        vectors++;
        if (bus.frame_tick !== 1'b1) begin
            miscompares++;
            $display("FAIL coinc_tick: got %b want 1", bus.frame_tick);
        end
        bus.value = 16'h3333;
        test_frame("coincident", 0, {4{7'b0110000}}, 4'b1111);
    endtask

    task automatic test_blank_reset();
        bus.value = 16'h4321;
        bus.blank = 4'b0010;
        test_frame("blank", 0,
                   {7'b0011001, 7'b0110000, 7'h7F, 7'b1111001}, 4'b1111);
        bus.blank = 4'b0000;
        repeat (7) tick();
        vectors++;
        if (bus.an !== 4'b1110) begin
            miscompares++;
            $display("FAIL pre_async_rst: got an=%b want 1110", bus.an);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_rst: got an=%b seg=%h dp=%b ft=%b want 1111/7f/1/0",
                     bus.an, bus.seg, bus.dp, bus.frame_tick);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.an, bus.seg} !== {4'b1110, 7'h40}) begin
            miscompares++;
            $display("FAIL rst_restart_d0: got an=%b seg=%h want 1110/40",
                     bus.an, bus.seg);
        end
        repeat (8) tick();
        vectors++;
        if ({bus.an, bus.seg} !== {4'b1101, 7'h40}) begin
            miscompares++;
            $display("FAIL rst_restart_d1: got an=%b seg=%h want 1101/40",
                     bus.an, bus.seg);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.value = '0;
        bus.dp_in = '0;
        bus.blank = '0;
        bus.lz_en = 1'b0;
        test_reset();
        test_full_frame();
        test_leading_zeros();
        test_tear_free();
        test_coincident();
        test_blank_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
